// File: rtl/mips_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core: button conditioning, core clock enable,
// register-file load arbitration and retired-instruction counter. Define MIPS_RUN_BREAKPOINT_EN for the PC breakpoint.
module mips_run_ctrl #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic             load_btn,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  output logic             cpu_en,
  output logic             rf_load_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  r_prev;
  logic [3:0]                  w_btn;
  logic [3:0]                  w_pulse;
  state_t                      r_state;
  logic                        r_skip;
  logic                        r_rf_load;
  logic                        r_halted;
  logic                        r_bp_hit;
  logic [CNT_W-1:0]            r_count;
  logic                        w_halt;
  logic                        w_run;
  logic                        w_step;
  logic                        w_load;
  logic                        w_bp_trap;
  logic                        w_cpu_en;

  // Bit order {load, step, run, halt}; the pulse is the rising edge of the synchronized level.
  assign w_btn   = {load_btn, step_btn, run_btn, halt_btn};
  assign w_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Coincident pulses resolve halt > run > step > load; losers are dropped.
  assign w_halt = w_pulse[0];
  assign w_run  = w_pulse[1] & ~w_pulse[0];
  assign w_step = w_pulse[2] & ~|w_pulse[1:0];
  assign w_load = w_pulse[3] & ~|w_pulse[2:0];

`ifdef MIPS_RUN_BREAKPOINT_EN
  assign w_bp_trap = (r_state == ST_RUN) && (pc == bp_addr) && !r_skip;
  assign bp_hit    = r_bp_hit;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{pc, bp_addr, r_skip, r_bp_hit};
  assign w_bp_trap   = 1'b0;
  assign bp_hit      = 1'b0;
`endif

  // A trapping RUN cycle withholds the enable so the breakpoint instruction does not retire.
  assign w_cpu_en = (r_state == ST_STEP) || ((r_state == ST_RUN) && !w_bp_trap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_HALT;
      r_skip    <= 1'b0;
      r_rf_load <= 1'b0;
      r_halted  <= 1'b1;
      r_bp_hit  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_rf_load <= 1'b0;
      r_skip    <= 1'b0;
      if (w_cpu_en) begin
        r_count <= r_count + 1'b1;
      end
      case (r_state)
        ST_HALT, ST_BREAK: begin
          if (w_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_run) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_bp_hit <= 1'b0;
            r_skip   <= (r_state == ST_BREAK);
          end else if (w_step) begin
            r_state  <= ST_STEP;
            r_halted <= 1'b0;
            r_bp_hit <= 1'b0;
          end else begin
            r_rf_load <= w_load;
          end
        end
        ST_STEP: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
          r_bp_hit <= 1'b0;
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_bp_trap) begin
            r_state  <= ST_BREAK;
            r_halted <= 1'b1;
            r_bp_hit <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
          r_bp_hit <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en      = w_cpu_en;
  assign rf_load_en  = r_rf_load;
  assign state       = r_state;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a per-cycle vector table driven through a scoreboard queue, plus
// hand-written reset, counter-wrap and breakpoint sequences (expectations follow MIPS_RUN_BREAKPOINT_EN).
`timescale 1ns/1ps
module tb_mips_run_ctrl;

  localparam int CW = 4;
  localparam int SS = 2;
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_STEP = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;

  // One record: inputs held for n cycles, expectations for the outputs seen in the last of them.
  typedef struct {
    logic       rst;
    logic       run;
    logic       step;
    logic       halt;
    logic       load;
    int         n;
    logic [1:0] st;
    logic       en;
    logic       ld;
    int         cnt;
  } vec_t;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic       en;
    logic       ld;
    int         cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          runBtn = 1'b0;
  logic          stepBtn = 1'b0;
  logic          haltBtn = 1'b0;
  logic          loadBtn = 1'b0;
  logic          pcClear = 1'b1;
  logic [31:0]   pc = 32'h0;
  logic [31:0]   bpAddr = 32'hFFFF_FFF0;
  logic          cpuEn;
  logic          rfLoadEn;
  logic [1:0]    stateOut;
  logic          haltedOut;
  logic          bpHit;
  logic [CW-1:0] instrCount;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   vecId = 0;
  exp_t expQ[$];
  exp_t monE;
  vec_t tbl[$];

  mips_run_ctrl #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (runBtn),
    .step_btn    (stepBtn),
    .halt_btn    (haltBtn),
    .load_btn    (loadBtn),
    .pc          (pc),
    .bp_addr     (bpAddr),
    .cpu_en      (cpuEn),
    .rf_load_en  (rfLoadEn),
    .state       (stateOut),
    .halted      (haltedOut),
    .bp_hit      (bpHit),
    .instr_count (instrCount)
  );

  always #5 clk = ~clk;

  // Stand-in for the core: the PC advances by one word on every enabled edge.
  always @(posedge clk) begin
    if (pcClear) pc <= 32'h0;
    else if (cpuEn) pc <= pc + 32'd4;
  end

  function automatic vec_t mk(input logic rst, run, step, halt, load, input int n,
                              input logic [1:0] st, input logic en, ld, input int cnt);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.halt = halt; v.load = load;
    v.n = n; v.st = st; v.en = en; v.ld = ld; v.cnt = cnt;
    return v;
  endfunction

  task automatic compareField(input int id, input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL vec%0d %s: got %0d, expected %0d", id, name, actual, expected);
    end
  endtask

  task automatic checkOutput(input int id, input logic [1:0] st, input logic en, input logic ld, input int cnt);
    compareField(id, "state", int'(stateOut), int'(st));
    compareField(id, "cpu_en", int'(cpuEn), int'(en));
    compareField(id, "rf_load_en", int'(rfLoadEn), int'(ld));
    compareField(id, "halted", int'(haltedOut), int'((st == S_HALT) || (st == S_BRK)));
    compareField(id, "bp_hit", int'(bpHit), int'(st == S_BRK));
    compareField(id, "instr_count", int'(instrCount), cnt % (1 << CW));
  endtask

  // Inputs change on the falling edge; the expectation is queued on the record's last cycle.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      reset   = v.rst;
      pcClear = v.rst;
      runBtn  = v.run;
      stepBtn = v.step;
      haltBtn = v.halt;
      loadBtn = v.load;
      if (k == v.n - 1) begin
        e.id = vecId; e.st = v.st; e.en = v.en; e.ld = v.ld; e.cnt = v.cnt;
        expQ.push_back(e);
      end
    end
    vecId++;
  endtask

  // Outputs are compared 1ns after the falling edge, well clear of the rising edge.
  always @(negedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput(monE.id, monE.st, monE.en, monE.ld, monE.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Step held through reset release: exactly one enabled cycle, then back to HALT.
    tbl.push_back(mk(1,0,1,0,0, 4, S_HALT,0,0, 0));
    tbl.push_back(mk(0,0,1,0,0, 3, S_HALT,0,0, 0));
    tbl.push_back(mk(0,0,1,0,0, 1, S_STEP,1,0, 0));
    tbl.push_back(mk(0,0,1,0,0, 1, S_HALT,0,0, 1));
    tbl.push_back(mk(0,0,1,0,0, 6, S_HALT,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 4, S_HALT,0,0, 1));
    // Load in HALT: a single-cycle strobe while the button stays held.
    tbl.push_back(mk(0,0,0,0,1, 3, S_HALT,0,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 1, S_HALT,0,1, 1));
    tbl.push_back(mk(0,0,0,0,1, 1, S_HALT,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 4, S_HALT,0,0, 1));
    // Run for exactly 20 cycles with a dropped load press in the middle.
    tbl.push_back(mk(0,1,0,0,0, 3, S_HALT,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 1, S_RUN, 1,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 4, S_RUN, 1,0, 5));
    tbl.push_back(mk(0,0,0,0,1, 3, S_RUN, 1,0, 8));
    tbl.push_back(mk(0,0,0,0,0, 1, S_RUN, 1,0, 9));
    tbl.push_back(mk(0,0,0,0,0, 8, S_RUN, 1,0, 17));
    tbl.push_back(mk(0,0,0,1,0, 3, S_RUN, 1,0, 20));
    tbl.push_back(mk(0,0,0,0,0, 1, S_HALT,0,0, 21));
    tbl.push_back(mk(0,0,0,0,0, 3, S_HALT,0,0, 21));
    // Run and load together: run wins, no strobe.
    tbl.push_back(mk(0,1,0,0,1, 3, S_HALT,0,0, 21));
    tbl.push_back(mk(0,0,0,0,0, 1, S_RUN, 1,0, 21));
    tbl.push_back(mk(0,0,0,0,0, 1, S_RUN, 1,0, 22));
    tbl.push_back(mk(0,0,0,1,0, 3, S_RUN, 1,0, 25));
    tbl.push_back(mk(0,0,0,0,0, 1, S_HALT,0,0, 26));
    tbl.push_back(mk(0,0,0,0,0, 3, S_HALT,0,0, 26));
    // Halt and step together: halt wins, nothing executes.
    tbl.push_back(mk(0,0,1,1,0, 3, S_HALT,0,0, 26));
    tbl.push_back(mk(0,0,0,0,0, 1, S_HALT,0,0, 26));
    tbl.push_back(mk(0,0,0,0,0, 3, S_HALT,0,0, 26));
    // Step and load together: step wins, no strobe.
    tbl.push_back(mk(0,0,1,0,1, 3, S_HALT,0,0, 26));
    tbl.push_back(mk(0,0,0,0,0, 1, S_STEP,1,0, 26));
    tbl.push_back(mk(0,0,0,0,0, 1, S_HALT,0,0, 27));
    tbl.push_back(mk(0,0,0,0,0, 3, S_HALT,0,0, 27));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Counter wrap: 17 single steps from reset leave the 4-bit count at 1.
    applyStimulus(mk(1,0,0,0,0, 2, S_HALT,0,0, 0));
    for (int s = 0; s < 17; s++) begin
      applyStimulus(mk(0,0,1,0,0, 1, S_HALT,0,0, s));
      applyStimulus(mk(0,0,0,0,0, 2, S_HALT,0,0, s));
      applyStimulus(mk(0,0,0,0,0, 1, S_STEP,1,0, s));
      applyStimulus(mk(0,0,0,0,0, 1, S_HALT,0,0, s + 1));
      applyStimulus(mk(0,0,0,0,0, 2, S_HALT,0,0, s + 1));
    end

    // Breakpoint at 0x0C with the PC advancing from 0.
    bpAddr = 32'h0000_000C;
    applyStimulus(mk(1,0,0,0,0, 2, S_HALT,0,0, 0));
    applyStimulus(mk(0,1,0,0,0, 3, S_HALT,0,0, 0));
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 1,0, 0));
    applyStimulus(mk(0,0,0,0,0, 2, S_RUN, 1,0, 2));
`ifdef MIPS_RUN_BREAKPOINT_EN
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 0,0, 3));
    applyStimulus(mk(0,0,0,0,0, 1, S_BRK, 0,0, 3));
    applyStimulus(mk(0,0,0,0,0, 2, S_BRK, 0,0, 3));
    applyStimulus(mk(0,0,0,0,1, 3, S_BRK, 0,0, 3));
    applyStimulus(mk(0,0,0,0,0, 1, S_BRK, 0,1, 3));
    applyStimulus(mk(0,0,0,0,0, 3, S_BRK, 0,0, 3));
    applyStimulus(mk(0,1,0,0,0, 3, S_BRK, 0,0, 3));
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 1,0, 3));
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 1,0, 4));
    applyStimulus(mk(0,0,0,1,0, 3, S_RUN, 1,0, 7));
    applyStimulus(mk(0,0,0,0,0, 1, S_HALT,0,0, 8));
`else
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 1,0, 3));
    applyStimulus(mk(0,0,0,0,0, 1, S_RUN, 1,0, 4));
    applyStimulus(mk(0,0,0,1,0, 3, S_RUN, 1,0, 7));
    applyStimulus(mk(0,0,0,0,0, 1, S_HALT,0,0, 8));
`endif

    // Reset asserted mid-RUN must stop the core before the next rising edge.
    applyStimulus(mk(0,1,0,0,0, 3, S_HALT,0,0, 8));
    applyStimulus(mk(0,0,0,0,0, 2, S_RUN, 1,0, 9));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput(vecId, S_HALT, 1'b0, 1'b0, 0);
    vecId++;
    applyStimulus(mk(1,0,0,0,0, 2, S_HALT,0,0, 0));
    applyStimulus(mk(0,0,0,0,0, 3, S_HALT,0,0, 0));

    @(negedge clk);
    #2;
    compareField(vecId, "scoreboard_drain", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
